dmem_access: RTL and testbench

Data-memory access controller for the MEM stage of the five-stage pipeline. It takes the registered EX/MEM address, store data and RMEM/WMEM controls, and runs a req/ack transaction on an external data-memory bus with variable latency. It holds `stall` high until the access completes, which lets the pipeline controller freeze IF..MEM and bubble WB. It then presents registered load data `d` to the MEM/WB registers.

---
 rtl/dmem_access_pkg.sv | 23 ++
 rtl/dmem_access_wdt.sv | 28 ++
 rtl/dmem_access.sv | 129 ++++++++++++
 tb/tb_dmem_access.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/dmem_access_pkg.sv
// rtl/dmem_access_pkg.sv - shared types and constants for the MEM-stage data-memory controller
// Purpose: state enum, default timeout load data, and bus-status debug word packing
//          ({state, bus_err, misalign, counter} at debug address 24).
// Ports: none (package).
package dmem_access_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [31:0] ERR_DATA_DEFAULT    = 32'hDEAD_BEEF;
  localparam int          DBG_ADDR_BUS_STATUS = 24;
  localparam int          DBG_CNT_W           = 8;

  function automatic logic [31:0] pack_bus_status(input state_t st, input logic err,
                                                  input logic mis,
                                                  input logic [DBG_CNT_W-1:0] cnt);
    return {20'd0, st, err, mis, cnt};
  endfunction

endpackage

// File: rtl/dmem_access_wdt.sv
// rtl/dmem_access_wdt.sv - saturating bus-timeout counter for the data-memory controller
// Purpose: counts while en is high, clears on clr, saturates at TIMEOUT-1.
// Ports: clk, rst (sync, active-high), clr, en, expired = (count == TIMEOUT-1).
module dmem_wdt #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [W-1:0] count;

  assign expired = (count == W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en && !expired) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/dmem_access.sv
// rtl/dmem_access.sv - MEM-stage data-memory access controller (req/ack bus, stall, timeout)
// Purpose: issues one bus request per load/store, stalls the pipeline until ack or
//          timeout, and registers load data into d. Optional macro DMEM_ALIGN_CHECK_EN
//          rejects misaligned accesses without touching the bus and adds the misalign port.
// Ports: clk, rst (sync, active-high); alu_out, FQ2, RMEM, WMEM, advance from EX/MEM;
//        bus_req/bus_we/bus_addr/bus_wdata/bus_ack/bus_rdata memory bus;
//        d (load data), stall, bus_err, misalign (macro only).
module dmem_access
  import dmem_access_pkg::*;
#(
  parameter int          TIMEOUT  = 16,
  parameter logic [31:0] ERR_DATA = ERR_DATA_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] alu_out,
  input  logic [31:0] FQ2,
  input  logic        RMEM,
  input  logic        WMEM,
  input  logic        advance,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [31:0] d,
  output logic        stall,
  output logic        bus_err
`ifdef DMEM_ALIGN_CHECK_EN
  , output logic      misalign
`endif
);

  state_t state, next;
  logic   op, misal, req_c, stall_c, wdt_clr, wdt_en, expired, timeout;

  assign op = RMEM | WMEM;

`ifdef DMEM_ALIGN_CHECK_EN
  assign misal = op && (alu_out[1:0] != 2'b00);
`else
  assign misal = 1'b0;
`endif

  // The request cycle in IDLE is the first stall cycle, so WAIT may last only
  // TIMEOUT-1 cycles for the whole access to cost exactly TIMEOUT stall cycles.
  dmem_wdt #(.TIMEOUT(TIMEOUT - 1)) u_wdt (
    .clk     (clk),
    .rst     (rst),
    .clr     (wdt_clr),
    .en      (wdt_en),
    .expired (expired)
  );

  always_comb begin
    next    = state;
    req_c   = 1'b0;
    stall_c = 1'b0;
    wdt_clr = 1'b0;
    wdt_en  = 1'b0;
    timeout = 1'b0;
    case (state)
      ST_IDLE: begin
        wdt_clr = 1'b1;
        if (op) begin
          stall_c = 1'b1;
          if (misal) begin
            next = ST_DONE;
          end else begin
            req_c = 1'b1;
            next  = bus_ack ? ST_DONE : ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        req_c   = 1'b1;
        stall_c = 1'b1;
        wdt_en  = 1'b1;
        timeout = !bus_ack && expired;
        if (bus_ack || expired) next = ST_DONE;
      end
      ST_DONE: begin
        // Held until the pipeline advances so a frozen pipeline never replays a store.
        if (advance) next = ST_IDLE;
      end
      default: next = ST_IDLE;
    endcase
  end

  assign bus_req   = req_c & ~rst;
  assign stall     = stall_c & ~rst;
  assign bus_we    = WMEM & bus_req;
  assign bus_addr  = alu_out & 32'hFFFF_FFFC;
  assign bus_wdata = FQ2;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      d       <= '0;
      bus_err <= 1'b0;
    end else begin
      state <= next;
      if (req_c && bus_ack && RMEM) begin
        d <= bus_rdata;
      end else if (timeout && RMEM) begin
        d <= ERR_DATA;
      end
      if (timeout) begin
        bus_err <= 1'b1;
      end else if (state == ST_DONE && advance) begin
        bus_err <= 1'b0;
      end
    end
  end

`ifdef DMEM_ALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      misalign <= 1'b0;
    end else if (state == ST_IDLE && misal) begin
      misalign <= 1'b1;
    end else if (state == ST_DONE && advance) begin
      misalign <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_access.sv
// tb/tb_dmem_access.sv - randomized self-checking bench for dmem_access
module tb_dmem_access;

  localparam int          TIMEOUT = 16;
  localparam logic [31:0] ERR     = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] alu_out, FQ2, bus_rdata;
  logic        RMEM, WMEM, advance, bus_ack;
  logic        bus_req, bus_we, stall, bus_err;
  logic [31:0] bus_addr, bus_wdata, d;
`ifdef DMEM_ALIGN_CHECK_EN
  logic        misalign;
`endif

  int          total = 0;
  int          bad   = 0;
  int          writes = 0;
  logic [31:0] exp_d = 32'd0;

  always #5 clk = ~clk;

  dmem_access #(.TIMEOUT(TIMEOUT), .ERR_DATA(ERR)) dut (
    .clk       (clk),
    .rst       (rst),
    .alu_out   (alu_out),
    .FQ2       (FQ2),
    .RMEM      (RMEM),
    .WMEM      (WMEM),
    .advance   (advance),
    .bus_ack   (bus_ack),
    .bus_rdata (bus_rdata),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .d         (d),
    .stall     (stall),
    .bus_err   (bus_err)
`ifdef DMEM_ALIGN_CHECK_EN
    , .misalign (misalign)
`endif
  );

  // Completed writes as seen by the memory.
  always @(posedge clk) if (!rst && bus_req && bus_we && bus_ack) writes <= writes + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  // One load/store. lat = cycle index (0 = request cycle) on which ack arrives;
  // lat >= TIMEOUT means no ack. freeze = DONE cycles with advance held low.
  task automatic access(input bit is_load, input logic [31:0] addr, input logic [31:0] wd,
                        input int lat, input logic [31:0] rd, input int freeze);
    int n_stall, n_req, bad_seq, frz_bad, exp_stall, w0;
    bit tout;
    w0 = writes;
    @(negedge clk);
    advance = 1'b0; RMEM = is_load; WMEM = !is_load;
    alu_out = addr; FQ2 = wd; bus_rdata = rd;
    n_stall = 0; n_req = 0; bad_seq = 0;
    for (int i = 0; i < 64; i++) begin
      if (i > 0) @(negedge clk);
      bus_ack = (i == lat);
      #1;
      if (!stall) break;
      n_stall++;
      if (bus_req) n_req++;
      if (bus_req && (bus_addr !== {addr[31:2], 2'b00} || bus_we !== !is_load || bus_wdata !== wd))
        bad_seq++;
    end
    tout      = (lat >= TIMEOUT);
    exp_stall = tout ? TIMEOUT : lat + 1;
    if (is_load) exp_d = tout ? ERR : rd;
    check("stall_cycles", n_stall, exp_stall);
    check("req_cycles", n_req, exp_stall);
    check("addr_we_seq", bad_seq, 0);
    check("done_req_low", 32'(bus_req), 0);
    check("done_d", d, exp_d);
    check("done_bus_err", 32'(bus_err), 32'(tout));
    bus_ack = 1'b0;
    frz_bad = 0;
    for (int f = 0; f < freeze; f++) begin
      @(negedge clk);
      bus_ack = 1'($urandom_range(0, 1));
      bus_rdata = $urandom;
      #1;
      if (bus_req || stall || d !== exp_d) frz_bad++;
    end
    if (freeze > 0) check("freeze_quiet", frz_bad, 0);
    check("write_count", writes - w0, 32'((!is_load) && !tout));
    @(negedge clk);
    bus_ack = 1'b0; advance = 1'b1;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    RMEM = 1'b0; WMEM = 1'b0;
    advance = 1'($urandom_range(0, 1));
    bus_ack = 1'($urandom_range(0, 1));
    bus_rdata = $urandom;
    #1;
    check("idle_stall", 32'(stall), 0);
    check("idle_req", 32'(bus_req), 0);
    check("idle_err", 32'(bus_err), 0);
    check("idle_d", d, exp_d);
  endtask

  initial begin
    logic [31:0] a;
    rst = 1'b1; RMEM = 1'b1; WMEM = 1'b0; advance = 1'b0; bus_ack = 1'b0;
    alu_out = 32'h40; FQ2 = 32'd0; bus_rdata = 32'd0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_req", 32'(bus_req), 0);
    check("rst_stall", 32'(stall), 0);
    check("rst_d", d, 0);
    check("rst_err", 32'(bus_err), 0);
    @(negedge clk);
    rst = 1'b0; RMEM = 1'b0;

    access(1'b1, 32'h40, 32'h0, 0, 32'h1234_5678, 0);
    idle_cycle();
    access(1'b0, 32'h80, 32'hCAFE_F00D, 3, 32'h0, 5);
    idle_cycle();
    access(1'b1, 32'h100, 32'h0, 99, 32'h5555_AAAA, 2);
    idle_cycle();
    access(1'b1, 32'h200, 32'h0, TIMEOUT - 1, 32'h0BAD_CAFE, 0);
    access(1'b0, 32'h204, 32'h1111_2222, 0, 32'h0, 0);
    idle_cycle();

    // Reset in the second WAIT cycle abandons the load.
    @(negedge clk);
    advance = 1'b0; RMEM = 1'b1; WMEM = 1'b0; alu_out = 32'h300; bus_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midwait_rst_req", 32'(bus_req), 0);
    check("midwait_rst_stall", 32'(stall), 0);
    @(negedge clk);
    rst = 1'b0; RMEM = 1'b0;
    #1;
    exp_d = 32'd0;
    check("after_rst_stall", 32'(stall), 0);
    check("after_rst_d", d, exp_d);
    check("after_rst_req", 32'(bus_req), 0);

    for (int k = 0; k < 30; k++) begin
      a = $urandom;
`ifdef DMEM_ALIGN_CHECK_EN
      a[1:0] = 2'b00;
`endif
      access(1'($urandom_range(0, 1)), a, $urandom,
             ($urandom_range(0, 7) == 0) ? 40 : int'($urandom_range(0, 5)),
             $urandom, int'($urandom_range(0, 3)));
      if ($urandom_range(0, 2) == 0) idle_cycle();
    end
    idle_cycle();

`ifdef DMEM_ALIGN_CHECK_EN
    @(negedge clk);
    advance = 1'b0; RMEM = 1'b0; WMEM = 1'b1; alu_out = 32'h42; bus_ack = 1'b0;
    #1;
    check("mis_stall", 32'(stall), 1);
    check("mis_req", 32'(bus_req), 0);
    @(negedge clk);
    #1;
    check("mis_flag", 32'(misalign), 1);
    check("mis_done_stall", 32'(stall), 0);
    check("mis_d", d, exp_d);
    advance = 1'b1;
    @(negedge clk);
    WMEM = 1'b0; advance = 1'b0;
    #1;
    check("mis_clear", 32'(misalign), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
